// File: rtl/config_pkg.sv
// Shared constants for the configuration shifter slice.
// CONFIG_SHIFTER_PARITY_EN adds one trailing even-parity bit per frame.
package config_pkg;

`ifdef CONFIG_SHIFTER_PARITY_EN
  localparam int unsigned CFG_PARITY_BITS = 1;
`else
  localparam int unsigned CFG_PARITY_BITS = 0;
`endif

  // A one-bit frame still needs a one-bit counter.
  function automatic int unsigned cfg_cnt_width(input int unsigned w);
    int unsigned cw;
    cw = $clog2(w);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/config_frame_counter.sv
// Frame bit counter: counts enabled shifts 0..W-1, wraps, and strobes on the wrap.
// Clear wins over enable and never produces a strobe.
module config_frame_counter
  import config_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = cfg_cnt_width(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          frame_done
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    frame_done = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CW'(W - 1)) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/config_shifter.sv
// Serial-to-parallel configuration loader feeding config_latch, daisy-chainable via cfg_out.
// CONFIG_SHIFTER_PARITY_EN appends an even-parity bit; bad frames pulse parity_err instead of set.
module config_shifter
  import config_pkg::*;
#(
  parameter int unsigned LENGTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_in,
  input  logic              cfg_en,
  input  logic              cfg_clear,
  output logic              cfg_out,
  output logic [LENGTH-1:0] shifter_data,
  output logic              set,
  output logic              busy,
  output logic              parity_err
);

  localparam int unsigned P  = CFG_PARITY_BITS;
  localparam int unsigned W  = LENGTH + P;
  localparam int unsigned CW = cfg_cnt_width(W);

  logic [W-1:0]  sr_q, sr_d;
  logic          set_q, set_d;
  logic          shift;
  logic          frame_done;
  // Frame position is only of interest when probing the design.
  logic [CW-1:0] cnt_unused;

  assign shift = cfg_en && !cfg_clear;

  config_frame_counter #(
    .W  (W),
    .CW (CW)
  ) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (cfg_en),
    .clear      (cfg_clear),
    .cnt        (cnt_unused),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Concatenate-and-truncate keeps the shift legal even for a one-bit chain.
  always_comb begin
    sr_d = sr_q;
    if (shift) begin
      sr_d = W'({sr_q, cfg_in});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      set_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      set_q <= set_d;
    end
  end

`ifdef CONFIG_SHIFTER_PARITY_EN
  logic parity_bad;
  logic parity_err_q, parity_err_d;

  // Checked on the incoming word so the verdict lands on the same edge as the last bit.
  assign parity_bad = ^sr_d;

  always_comb begin
    set_d        = frame_done && !parity_bad;
    parity_err_d = frame_done && parity_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  always_comb begin
    set_d = frame_done;
  end

  assign parity_err = 1'b0;
`endif

  assign set          = set_q;
  assign cfg_out      = sr_q[W-1];
  assign shifter_data = sr_q[W-1:P];

endmodule

// File: tb/tb_config_shifter.sv
// Directed bench for config_shifter: framing, gaps, clear, reset, parity/back-to-back, daisy chain.
// Works in both builds of CONFIG_SHIFTER_PARITY_EN.
module tb_config_shifter;
  import config_pkg::*;

  localparam int LENGTH = 8;
  localparam int W      = LENGTH + int'(CFG_PARITY_BITS);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_in = 1'b0;
  logic              cfg_en = 1'b0;
  logic              cfg_clear = 1'b0;

  logic              n_out, n_set, n_busy, n_perr;
  logic [LENGTH-1:0] n_data;
  logic              f_out, f_set, f_busy, f_perr;
  logic [LENGTH-1:0] f_data;

  int n_cmp = 0;
  int n_err = 0;
  int early = 0;

  always #5 clk = ~clk;

  config_shifter #(.LENGTH(LENGTH)) u_near (
    .clk          (clk),
    .rst          (rst),
    .cfg_in       (cfg_in),
    .cfg_en       (cfg_en),
    .cfg_clear    (cfg_clear),
    .cfg_out      (n_out),
    .shifter_data (n_data),
    .set          (n_set),
    .busy         (n_busy),
    .parity_err   (n_perr)
  );

  config_shifter #(.LENGTH(LENGTH)) u_far (
    .clk          (clk),
    .rst          (rst),
    .cfg_in       (n_out),
    .cfg_en       (cfg_en),
    .cfg_clear    (cfg_clear),
    .cfg_out      (f_out),
    .shifter_data (f_data),
    .set          (f_set),
    .busy         (f_busy),
    .parity_err   (f_perr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame bits right-aligned, MSB first at bit W-1; parity bit appended when built in.
  function automatic logic [15:0] mkframe(input logic [7:0] d, input logic pbit);
    logic [15:0] f;
    if (CFG_PARITY_BITS != 0) f = {7'b0, d, pbit};
    else                      f = {8'b0, d};
    return f;
  endfunction

  task automatic drive_bit(input logic b);
    @(negedge clk);
    cfg_in    = b;
    cfg_en    = 1'b1;
    cfg_clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Leaves cfg_en high so a following call runs back-to-back.
  task automatic shift_frame(input logic [15:0] f, input bit gaps);
    early = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (gaps) begin
        @(negedge clk);
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        if (n_set || n_perr) early++;
      end
      drive_bit(f[i]);
      if (i != 0 && (n_set || n_perr)) early++;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cfg_en    = 1'b0;
    cfg_clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", n_data, 0);
    chk("rst_cfg_out", n_out, 0);
    chk("rst_busy", n_busy, 0);
    chk("rst_set", n_set, 0);
    chk("rst_perr", n_perr, 0);
    @(negedge clk);
    rst = 1'b1;

    // Plain frame
    shift_frame(mkframe(8'hA5, 1'b0), 1'b0);
    chk("t1_early", early, 0);
    chk("t1_set", n_set, 1);
    chk("t1_data", n_data, 32'hA5);
    chk("t1_busy", n_busy, 0);
    chk("t1_cfg_out", n_out, 1);
    idle(1);
    chk("t1_set_one_cycle", n_set, 0);

    // Idle cycle before every bit
    shift_frame(mkframe(8'hA5, 1'b0), 1'b1);
    chk("t2_early", early, 0);
    chk("t2_set", n_set, 1);
    chk("t2_data", n_data, 32'hA5);
    idle(1);
    chk("t2_set_one_cycle", n_set, 0);

    // Abort after 5 bits; clear with a simultaneous enable
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    chk("t3_busy_partial", n_busy, 1);
    @(negedge clk);
    cfg_in    = 1'b0;
    cfg_en    = 1'b1;
    cfg_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_clear_set", n_set, 0);
    chk("t3_clear_busy", n_busy, 0);
    shift_frame(mkframe(8'h3C, 1'b0), 1'b0);
    chk("t3_early", early, 0);
    chk("t3_set", n_set, 1);
    chk("t3_data", n_data, 32'h3C);
    idle(1);

    // Reset mid-frame
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("t4_busy_partial", n_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t4_rst_data", n_data, 0);
    chk("t4_rst_cfg_out", n_out, 0);
    chk("t4_rst_busy", n_busy, 0);
    chk("t4_rst_set", n_set, 0);
    @(negedge clk);
    rst    = 1'b1;
    cfg_en = 1'b0;
    shift_frame(mkframe(8'hFF, 1'b0), 1'b0);
    chk("t4_early", early, 0);
    chk("t4_set", n_set, 1);
    chk("t4_data", n_data, 32'hFF);
    chk("t4_perr", n_perr, 0);
    idle(1);

`ifdef CONFIG_SHIFTER_PARITY_EN
    // Good parity then bad parity, back-to-back
    shift_frame(mkframe(8'hA5, 1'b0), 1'b0);
    chk("t5_good_set", n_set, 1);
    chk("t5_good_perr", n_perr, 0);
    chk("t5_good_data", n_data, 32'hA5);
    shift_frame(mkframe(8'hA5, 1'b1), 1'b0);
    chk("t5_bad_early", early, 0);
    chk("t5_bad_perr", n_perr, 1);
    chk("t5_bad_set", n_set, 0);
    chk("t5_bad_data", n_data, 32'hA5);
    idle(1);
    chk("t5_perr_one_cycle", n_perr, 0);
`else
    // Back-to-back frames with no idle cycle
    shift_frame(mkframe(8'h5A, 1'b0), 1'b0);
    chk("t5_first_set", n_set, 1);
    chk("t5_first_data", n_data, 32'h5A);
    shift_frame(mkframe(8'hC3, 1'b0), 1'b0);
    chk("t5_second_early", early, 0);
    chk("t5_second_set", n_set, 1);
    chk("t5_second_data", n_data, 32'hC3);
    idle(1);
    chk("t5_set_one_cycle", n_set, 0);
`endif

    // Daisy chain: first frame ends up in the far shifter
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    shift_frame(mkframe(8'h12, 1'b0), 1'b0);
    shift_frame(mkframe(8'h34, 1'b1), 1'b0);
    chk("t6_near_data", n_data, 32'h34);
    chk("t6_far_data", f_data, 32'h12);
    chk("t6_near_set", n_set, 1);
    chk("t6_far_set", f_set, 1);
    chk("t6_far_perr", f_perr, 0);
    idle(1);
    chk("t6_far_set_one_cycle", f_set, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
